// File: rtl/nway_cache_control_if.sv
// Handshake and status bundle between the cache controller, its datapath,
// the CPU side and physical memory.
interface nway_cache_control_if #(
  parameter int WAYS = 4,
  parameter int SETS = 8
);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;

  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          mem_byte_enable256;
  logic [SW-1:0]        set_idx;
  logic [WAYS-1:0]      hit;
  logic [WAYS-1:0]      valid;
  logic [WAYS-1:0]      dirty;
  logic                 pmem_resp;

  logic                 mem_resp;
  logic                 pmem_read;
  logic                 pmem_write;
  logic                 pmem_address_sel;
  logic                 data_in_sel;
  logic [WW-1:0]        way_sel;
  logic [WAYS*32-1:0]   load_data;
  logic [WAYS-1:0]      load_tag;
  logic [WAYS-1:0]      load_valid;
  logic [WAYS-1:0]      load_dirty;
  logic                 valid_in;
  logic                 dirty_in;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable256, set_idx,
           hit, valid, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_address_sel, data_in_sel,
           way_sel, load_data, load_tag, load_valid, load_dirty,
           valid_in, dirty_in
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable256, set_idx,
           hit, valid, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_address_sel, data_in_sel,
           way_sel, load_data, load_tag, load_valid, load_dirty,
           valid_in, dirty_in
  );
endinterface

// File: rtl/nway_cache_control.sv
// N-way set-associative cache controller: hit handling, dirty writeback,
// line fill, and tree pseudo-LRU replacement per set.
module nway_cache_control #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  nway_cache_control_if.slave  bus
);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    ST_CHECK     = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     victim_q, victim_d;
  logic [WAYS-2:0]   plru_q [SETS];

  logic              req_s;
  logic              hit_any_s;
  logic [WW-1:0]     hit_way_s;
  logic [WW-1:0]     miss_way_s;

  function automatic logic [WW-1:0] lowest_set(input logic [WAYS-1:0] v);
    logic [WW-1:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = WW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Walk the tree from the root, following each node's pointer to a leaf.
  function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] t);
    logic [WW-1:0] w;
    int            node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      w[WW-1-l] = t[node];
      node      = 2 * node + 1 + int'(t[node]);
    end
    return w;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [WW-1:0]   w);
    logic [WAYS-2:0] r;
    logic            b;
    int              node;
    r    = t;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      b       = w[WW-1-l];
      r[node] = ~b;
      node    = 2 * node + 1 + int'(b);
    end
    return r;
  endfunction

  assign req_s      = bus.mem_read | bus.mem_write;
  assign hit_any_s  = |bus.hit;
  assign hit_way_s  = lowest_set(bus.hit);
  assign miss_way_s = (&bus.valid) ? plru_victim(plru_q[bus.set_idx])
                                   : lowest_set(~bus.valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CHECK;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Only a CPU hit refreshes replacement state; fills leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else if (state_q == ST_CHECK && req_s && hit_any_s) begin
      plru_q[bus.set_idx] <= plru_touch(plru_q[bus.set_idx], hit_way_s);
    end else begin
      plru_q[bus.set_idx] <= plru_q[bus.set_idx];
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      ST_CHECK: begin
        if (req_s && !hit_any_s) begin
          victim_d = miss_way_s;
          if (bus.valid[miss_way_s] && bus.dirty[miss_way_s]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_WRITEBACK: begin
        if (bus.pmem_resp) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_FETCH: begin
        if (bus.pmem_resp) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_CHECK;
      end
    endcase
  end

  // While rst is high the outputs look like an idle CHECK cycle.
  always_comb begin
    bus.mem_resp         = 1'b0;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_address_sel = 1'b0;
    bus.data_in_sel      = 1'b0;
    bus.way_sel          = '0;
    bus.load_data        = '0;
    bus.load_tag         = '0;
    bus.load_valid       = '0;
    bus.load_dirty       = '0;
    bus.valid_in         = 1'b0;
    bus.dirty_in         = 1'b0;
    if (rst) begin
      bus.mem_resp = 1'b0;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (req_s && hit_any_s) begin
            bus.mem_resp = 1'b1;
            if (bus.mem_write) begin
              bus.data_in_sel                          = 1'b0;
              bus.load_data[32*int'(hit_way_s) +: 32]  = bus.mem_byte_enable256;
              bus.load_dirty[hit_way_s]                = 1'b1;
              bus.dirty_in                             = 1'b1;
            end else begin
              bus.way_sel = hit_way_s;
            end
          end else begin
            bus.mem_resp = 1'b0;
          end
        end
        ST_WRITEBACK: begin
          bus.pmem_write       = 1'b1;
          bus.pmem_address_sel = 1'b1;
          bus.way_sel          = victim_q;
        end
        ST_FETCH: begin
          bus.pmem_read                          = 1'b1;
          bus.pmem_address_sel                   = 1'b0;
          bus.data_in_sel                        = 1'b1;
          bus.load_data[32*int'(victim_q) +: 32] = 32'hFFFF_FFFF;
          bus.load_tag[victim_q]                 = 1'b1;
          bus.load_valid[victim_q]               = 1'b1;
          bus.valid_in                           = 1'b1;
          bus.load_dirty[victim_q]               = 1'b1;
          bus.dirty_in                           = 1'b0;
        end
        default: begin
          bus.mem_resp = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nway_cache_control.sv
// Directed bench for nway_cache_control (WAYS=4, SETS=8); expected values
// are hand-derived from the PLRU tree and FSM behaviour.
module tb_nway_cache_control;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  nway_cache_control_if #(.WAYS(4), .SETS(8)) bus ();

  nway_cache_control #(.WAYS(4), .SETS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge; checks run #1 later, well before the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst                    = 1'b1;
    bus.mem_read           = 1'b1;
    bus.mem_write          = 1'b0;
    bus.mem_byte_enable256 = 32'h0;
    bus.set_idx            = 3'd0;
    bus.hit                = 4'b0001;
    bus.valid              = 4'b1111;
    bus.dirty              = 4'b0000;
    bus.pmem_resp          = 1'b0;

    // Reset cycle looks idle even with a hit presented
    settle();
    check("rst_mem_resp", 128'(bus.mem_resp), 128'd0);
    check("rst_way_sel", 128'(bus.way_sel), 128'd0);
    step(); step();
    rst = 1'b0; bus.mem_read = 1'b0; bus.hit = 4'b0000;
    settle();
    check("idle_mem_resp", 128'(bus.mem_resp), 128'd0);
    check("idle_pmem_read", 128'(bus.pmem_read), 128'd0);
    check("idle_load_data", 128'(bus.load_data), 128'd0);

    // Clean miss, set 0: victim way 0
    step();
    bus.mem_read = 1'b1; bus.set_idx = 3'd0;
    settle();
    check("cm_check_resp", 128'(bus.mem_resp), 128'd0);
    step();
    settle();
    check("cm_pmem_read", 128'(bus.pmem_read), 128'd1);
    check("cm_load_data", 128'(bus.load_data), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    check("cm_load_valid", 128'(bus.load_valid), 128'h1);
    check("cm_load_dirty", 128'(bus.load_dirty), 128'h1);
    check("cm_flags", 128'({bus.valid_in, bus.dirty_in, bus.data_in_sel, bus.pmem_address_sel, bus.mem_resp}), 128'b10100);
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0; bus.hit = 4'b0001;
    settle();
    check("cm_rehit_resp", 128'(bus.mem_resp), 128'd1);
    check("cm_rehit_pread", 128'(bus.pmem_read), 128'd0);

    // Set 3: hit way 0 then way 2 leaves the PLRU victim at way 1
    step();
    bus.set_idx = 3'd3; bus.hit = 4'b0001;
    settle();
    check("rh0_way_sel", 128'(bus.way_sel), 128'd0);
    step();
    bus.hit = 4'b0100;
    settle();
    check("rh2_mem_resp", 128'(bus.mem_resp), 128'd1);
    check("rh2_way_sel", 128'(bus.way_sel), 128'd2);
    step();
    bus.hit = 4'b0000;
    settle();
    check("plru_miss_resp", 128'(bus.mem_resp), 128'd0);
    step();
    bus.valid = 4'b1110;
    settle();
    check("plru_victim1", 128'(bus.load_tag), 128'b0010);
    check("plru_victim1_data", 128'(bus.load_data), 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);
    bus.pmem_resp = 1'b1;
    settle();
    check("victim_held", 128'(bus.load_tag), 128'b0010);
    step();
    bus.pmem_resp = 1'b0; bus.hit = 4'b0010; bus.valid = 4'b1111;
    settle();
    check("plru_rehit", 128'(bus.mem_resp), 128'd1);

    // Dirty miss on set 3: PLRU now names way 3
    step();
    bus.hit = 4'b0000; bus.dirty = 4'b1000;
    step();
    settle();
    check("wb_pmem_write", 128'(bus.pmem_write), 128'd1);
    check("wb_addr_sel", 128'(bus.pmem_address_sel), 128'd1);
    check("wb_way_sel", 128'(bus.way_sel), 128'd3);
    check("wb_no_resp", 128'(bus.mem_resp), 128'd0);
    step();
    settle();
    check("wb_hold", 128'(bus.pmem_write), 128'd1);
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0;
    settle();
    check("wb_to_fetch_w", 128'(bus.pmem_write), 128'd0);
    check("wb_to_fetch_r", 128'(bus.pmem_read), 128'd1);
    check("wb_fetch_tag", 128'(bus.load_tag), 128'b1000);
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0; bus.hit = 4'b1000; bus.dirty = 4'b0000;
    settle();
    check("wb_rehit", 128'(bus.mem_resp), 128'd1);

    // Invalid way wins over PLRU (PLRU would choose way 0)
    step();
    bus.hit = 4'b0000; bus.valid = 4'b1011;
    step();
    settle();
    check("inv_priority", 128'(bus.load_tag), 128'b0100);
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0; bus.valid = 4'b1111; bus.hit = 4'b0001;
    settle();
    check("inv_rehit", 128'(bus.mem_resp), 128'd1);

    // Write hit with read also asserted is a write
    step();
    bus.set_idx = 3'd2; bus.mem_write = 1'b1; bus.hit = 4'b0010;
    bus.mem_byte_enable256 = 32'h0000_000F;
    settle();
    check("wh_mem_resp", 128'(bus.mem_resp), 128'd1);
    check("wh_load_data", 128'(bus.load_data), 128'h0000_0000_0000_0000_0000_000F_0000_0000);
    check("wh_load_dirty", 128'(bus.load_dirty), 128'b0010);
    check("wh_dirty_in", 128'(bus.dirty_in), 128'd1);
    check("wh_data_in_sel", 128'(bus.data_in_sel), 128'd0);

    // Multiple hits resolve to the lowest way
    step();
    bus.mem_write = 1'b0; bus.hit = 4'b0110;
    settle();
    check("multi_hit_way", 128'(bus.way_sel), 128'd1);

    // pmem_resp is ignored in CHECK
    step();
    bus.mem_read = 1'b0; bus.hit = 4'b0000; bus.pmem_resp = 1'b1;
    settle();
    check("idle_presp_resp", 128'(bus.mem_resp), 128'd0);
    step();
    bus.pmem_resp = 1'b0;
    settle();
    check("idle_presp_pmem", 128'({bus.pmem_read, bus.pmem_write}), 128'd0);

    // Reset mid-FETCH aborts and clears PLRU (set 3 would otherwise pick way 2)
    step();
    bus.mem_read = 1'b1; bus.set_idx = 3'd6;
    step();
    settle();
    check("rf_pmem_read", 128'(bus.pmem_read), 128'd1);
    rst = 1'b1;
    settle();
    check("rf_rst_cycle", 128'(bus.pmem_read), 128'd0);
    step();
    rst = 1'b0; bus.mem_read = 1'b0;
    settle();
    check("rf_after_rst", 128'({bus.pmem_read, bus.pmem_write}), 128'd0);
    step();
    bus.mem_read = 1'b1; bus.set_idx = 3'd3;
    step();
    settle();
    check("rf_plru_cleared", 128'(bus.load_tag), 128'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
